// File: rtl/wb_buffer_if.sv
// Writeback buffer bus bundle.
// Carries the request handshake (in_*), the register-file write port
// (drain_en, rf_*), the two forwarding lookups (ra*, fwd_*) and the
// occupancy status (count, empty, full).
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both high. in_ready does not depend on in_valid, and the
// requester holds in_wa/in_wd stable while in_valid is high.
//
// Modports:
//   slave  - the buffer itself
//   master - the stage/bench that issues requests and grants the port
interface wb_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] in_wa;
  logic [DWIDTH-1:0] in_wd;
  logic              drain_en;
  logic              rf_we;
  logic [AWIDTH-1:0] rf_wa;
  logic [DWIDTH-1:0] rf_wd;
  logic [AWIDTH-1:0] ra1;
  logic [AWIDTH-1:0] ra2;
  logic              fwd_hit1;
  logic [DWIDTH-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DWIDTH-1:0] fwd_data2;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;

  modport slave (
    input  in_valid, in_wa, in_wd, drain_en, ra1, ra2,
    output in_ready, rf_we, rf_wa, rf_wd,
    output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
    output count, empty, full
  );

  modport master (
    output in_valid, in_wa, in_wd, drain_en, ra1, ra2,
    input  in_ready, rf_we, rf_wa, rf_wd,
    input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
    input  count, empty, full
  );
endinterface

// File: rtl/wb_buffer.sv
// Writeback buffer in front of the register-file write port.
// Queues writeback requests in an in-order circular FIFO, drains the head
// into the register file whenever the write port is granted, and forwards
// the youngest queued value for each of the two read addresses.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset, discards all queued writes
//   bus   - wb_buffer_if.slave: request handshake, rf write port,
//           forwarding lookups and occupancy status
module wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [DEPTH-1:0]  valid_q;
  logic [AWIDTH-1:0] wa_q [DEPTH];
  logic [DWIDTH-1:0] wd_q [DEPTH];

  logic empty_w;
  logic full_w;
  logic push;
  logic pop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // in_ready looks only at the registered count, so a full buffer refuses
  // a request even in a cycle where the head is draining.
  assign bus.in_ready = !full_w;

  // Writes to x0 complete the handshake but are dropped.
  assign push = bus.in_valid && !full_w && (bus.in_wa != '0);
  assign pop  = bus.drain_en && !empty_w;

  assign bus.rf_we = pop;
  assign bus.rf_wa = empty_w ? '0 : wa_q[rd_ptr];
  assign bus.rf_wd = empty_w ? '0 : wd_q[rd_ptr];
  assign bus.count = count_q;
  assign bus.empty = empty_w;
  assign bus.full  = full_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wa_q[i] <= '0;
        wd_q[i] <= '0;
      end
    end else begin
      // push and pop never target the same slot: push needs !full, and
      // pop needs !empty, so rd_ptr == wr_ptr excludes one of them.
      if (push) begin
        wa_q[wr_ptr]    <= bus.in_wa;
        wd_q[wr_ptr]    <= bus.in_wd;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Scan from the head (oldest) towards the tail so that the last match
  // seen is the youngest one. The head still matches while it drains,
  // since the register file only updates at the edge. Incoming requests
  // are not yet in the array, so there is no same-cycle bypass.
  function automatic logic [DWIDTH:0] lookup(input logic [AWIDTH-1:0] ra);
    logic [DWIDTH:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (ra != '0 && valid_q[idx] && wa_q[idx] == ra)
        res = {1'b1, wd_q[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {bus.fwd_hit1, bus.fwd_data1} = lookup(bus.ra1);
    {bus.fwd_hit2, bus.fwd_data2} = lookup(bus.ra2);
  end
endmodule

// File: tb/tb_wb_buffer.sv
module tb_wb_buffer;
  localparam int DEPTH  = 4;
  localparam int AWIDTH = 5;
  localparam int DWIDTH = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_buffer_if #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

  wb_buffer #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of {wa, wd} in acceptance order; front is the next commit.
  logic [AWIDTH+DWIDTH-1:0] exp_q[$];
  int commits = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      automatic bit do_pop  = (exp_q.size() > 0) && bus.drain_en;
      automatic bit do_push = bus.in_valid && (exp_q.size() < DEPTH) &&
                              (bus.in_wa != 0);
      if (do_pop) begin
        void'(exp_q.pop_front());
        commits++;
      end
      if (do_push) exp_q.push_back({bus.in_wa, bus.in_wd});
    end
  end

  function automatic logic [DWIDTH:0] model_fwd(input logic [AWIDTH-1:0] ra);
    if (ra == 0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][AWIDTH+DWIDTH-1:DWIDTH] == ra)
        return {1'b1, exp_q[i][DWIDTH-1:0]};
    return '0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    automatic int n = rst_n ? exp_q.size() : 0;
    automatic logic [AWIDTH-1:0] e_wa = '0;
    automatic logic [DWIDTH-1:0] e_wd = '0;
    automatic logic [DWIDTH:0]   f1 = '0;
    automatic logic [DWIDTH:0]   f2 = '0;
    if (n > 0) begin
      e_wa = exp_q[0][AWIDTH+DWIDTH-1:DWIDTH];
      e_wd = exp_q[0][DWIDTH-1:0];
      f1   = model_fwd(bus.ra1);
      f2   = model_fwd(bus.ra2);
    end
    check("cmp_count",    64'(bus.count),    64'(n));
    check("cmp_empty",    64'(bus.empty),    64'(n == 0));
    check("cmp_full",     64'(bus.full),     64'(n == DEPTH));
    check("cmp_in_ready", 64'(bus.in_ready), 64'(n != DEPTH));
    check("cmp_rf_we",    64'(bus.rf_we),    64'((n > 0) && bus.drain_en));
    check("cmp_rf_wa",    64'(bus.rf_wa),    64'(e_wa));
    check("cmp_rf_wd",    64'(bus.rf_wd),    64'(e_wd));
    check("cmp_fwd1",     {31'd0, bus.fwd_hit1, bus.fwd_data1}, 64'(f1));
    check("cmp_fwd2",     {31'd0, bus.fwd_hit2, bus.fwd_data2}, 64'(f2));
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks sample on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic [AWIDTH-1:0] wa,
                         input logic [DWIDTH-1:0] wd);
    bus.in_valid = v;
    bus.in_wa    = wa;
    bus.in_wd    = wd;
  endtask

  task automatic push(input logic [AWIDTH-1:0] wa, input logic [DWIDTH-1:0] wd);
    set_req(1'b1, wa, wd);
    tick();
    set_req(1'b0, '0, '0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_req(1'b0, '0, '0);
    bus.drain_en = 1'b0;
    bus.ra1 = '0;
    bus.ra2 = '0;
    tick();
    tick();
    sample();
    check("rst_count",    64'(bus.count), 64'd0);
    check("rst_empty",    64'(bus.empty), 64'd1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_rf_wa",    64'(bus.rf_wa), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic flow
    push(5'd5, 32'hAAAA0001);
    push(5'd6, 32'hBBBB0002);
    bus.ra1 = 5'd5;
    sample();
    check("basic_count", 64'(bus.count), 64'd2);
    check("basic_fwd1",  {31'd0, bus.fwd_hit1, bus.fwd_data1}, {31'd0, 1'b1, 32'hAAAA0001});
    tick();
    bus.drain_en = 1'b1;
    sample();
    check("basic_we0", 64'(bus.rf_we), 64'd1);
    check("basic_wa0", 64'(bus.rf_wa), 64'd5);
    check("basic_wd0", 64'(bus.rf_wd), 64'hAAAA0001);
    tick();
    sample();
    check("basic_wa1", 64'(bus.rf_wa), 64'd6);
    check("basic_wd1", 64'(bus.rf_wd), 64'hBBBB0002);
    tick();
    sample();
    check("basic_empty", 64'(bus.empty), 64'd1);
    check("basic_wa_z",  64'(bus.rf_wa), 64'd0);
    check("basic_we_z",  64'(bus.rf_we), 64'd0);
    tick();
    bus.drain_en = 1'b0;

    // Full / backpressure
    for (int i = 1; i <= 4; i++) push(AWIDTH'(i), 32'h100 + i);
    set_req(1'b1, 5'd8, 32'h555);
    bus.drain_en = 1'b1;
    bus.ra1 = 5'd8;
    sample();
    check("full_full",     64'(bus.full), 64'd1);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_rf_wa",    64'(bus.rf_wa), 64'd1);
    tick();
    set_req(1'b0, '0, '0);
    bus.drain_en = 1'b0;
    sample();
    check("full_count3",   64'(bus.count), 64'd3);
    check("full_ready3",   64'(bus.in_ready), 64'd1);
    check("full_no_8",     64'(bus.fwd_hit1), 64'd0);
    tick();
    bus.drain_en = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      sample();
      check("full_drain_wa", 64'(bus.rf_wa), 64'(i));
      check("full_drain_wd", 64'(bus.rf_wd), 64'h100 + 64'(i));
      tick();
    end
    bus.drain_en = 1'b0;

    // x0 discard
    set_req(1'b1, 5'd0, 32'hDEADBEEF);
    bus.ra1 = 5'd0;
    sample();
    check("x0_ready", 64'(bus.in_ready), 64'd1);
    tick();
    set_req(1'b0, '0, '0);
    bus.drain_en = 1'b1;
    sample();
    check("x0_count", 64'(bus.count), 64'd0);
    check("x0_we",    64'(bus.rf_we), 64'd0);
    check("x0_hit1",  64'(bus.fwd_hit1), 64'd0);
    tick();
    bus.drain_en = 1'b0;

    // Forward youngest, no same-cycle bypass, draining head still hits
    push(5'd7, 32'h11);
    push(5'd3, 32'h22);
    push(5'd7, 32'h33);
    bus.ra1 = 5'd7;
    bus.ra2 = 5'd3;
    sample();
    check("fwd_y1", {31'd0, bus.fwd_hit1, bus.fwd_data1}, {31'd0, 1'b1, 32'h33});
    check("fwd_y2", {31'd0, bus.fwd_hit2, bus.fwd_data2}, {31'd0, 1'b1, 32'h22});
    tick();
    bus.ra1 = 5'd9;
    set_req(1'b1, 5'd9, 32'h44);
    sample();
    check("fwd_miss_hit",  64'(bus.fwd_hit1), 64'd0);
    check("fwd_miss_data", 64'(bus.fwd_data1), 64'd0);
    tick();
    set_req(1'b0, '0, '0);
    sample();
    check("fwd_late_9", {31'd0, bus.fwd_hit1, bus.fwd_data1}, {31'd0, 1'b1, 32'h44});
    tick();
    bus.ra1 = 5'd7;
    bus.drain_en = 1'b1;
    tick();
    tick();
    sample();
    check("fwd_head_drain", {31'd0, bus.fwd_hit1, bus.fwd_data1}, {31'd0, 1'b1, 32'h33});
    check("fwd_head_we",    64'(bus.rf_we), 64'd1);
    tick();
    tick();
    bus.drain_en = 1'b0;

    // Reset mid-stream with 3 entries queued
    push(5'd10, 32'hA);
    push(5'd11, 32'hB);
    push(5'd12, 32'hC);
    bus.drain_en = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mrst_count", 64'(bus.count), 64'd0);
    check("mrst_empty", 64'(bus.empty), 64'd1);
    check("mrst_we",    64'(bus.rf_we), 64'd0);
    check("mrst_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("mrst_no_commit", 64'(bus.rf_we), 64'd0);
      tick();
    end

    // Wrap with accept and drain every cycle
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, AWIDTH'(20 + i), 32'hC0DE0000 + i);
      sample();
      if (i > 0) begin
        check("wrap_count", 64'(bus.count), 64'd1);
        check("wrap_wa",    64'(bus.rf_wa), 64'(20 + i - 1));
        check("wrap_wd",    64'(bus.rf_wd), 64'hC0DE0000 + 64'(i - 1));
      end
      tick();
    end
    set_req(1'b0, '0, '0);
    sample();
    check("wrap_last_wa", 64'(bus.rf_wa), 64'd29);
    tick();
    sample();
    check("wrap_empty", 64'(bus.empty), 64'd1);
    tick();
    bus.drain_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_buffer.md
Name: wb_buffer

Overview:
Writeback buffer on the writer side of the register-file write port. It accepts writeback requests from the execute/memory stages over a valid/ready handshake and queues them in a small in-order FIFO. It drains the queue into the register file one write per cycle, driving we/wa/wd, whenever the port is granted. It also supplies forwarding data for the two register-file read addresses, so operand reads see queued but not-yet-committed values.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
AWIDTH, 5, register address width
DWIDTH, 32, register data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  writeback request valid
in_ready  output  1  buffer can accept a request
in_wa  input  AWIDTH  destination register of request
in_wd  input  DWIDTH  data of request
drain_en  input  1  register-file write port granted this cycle
rf_we  output  1  register-file write enable
rf_wa  output  AWIDTH  register-file write address
rf_wd  output  DWIDTH  register-file write data
ra1  input  AWIDTH  read address 1 (same as register-file ra1)
ra2  input  AWIDTH  read address 2
fwd_hit1  output  1  queued value exists for ra1
fwd_data1  output  DWIDTH  forwarded value for ra1
fwd_hit2  output  1  queued value exists for ra2
fwd_data2  output  DWIDTH  forwarded value for ra2
count  output  clog2(DEPTH+1)  occupied entries
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Reset (rst_n low, asynchronous): read and write pointers = 0; count = 0; all entry valid bits = 0. Outputs: empty = 1, full = 0, in_ready = 1, rf_we = 0, rf_wa = 0, rf_wd = 0, fwd_hit1 = 0, fwd_hit2 = 0, fwd_data1 = 0, fwd_data2 = 0. Reset mid-operation discards all queued writes; none are committed.
- Storage: circular FIFO of DEPTH entries {valid, wa, wd}. Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
- in_ready = !full. It is combinational from count and does not depend on drain_en, so a full buffer refuses a request even in a cycle where it drains.
- Accept: in_valid && in_ready at a rising edge.
  - If in_wa != 0: write the entry at the write pointer, set its valid bit, advance the write pointer.
  - If in_wa == 0: the handshake completes but nothing is enqueued; count is unchanged.
- Drain (all combinational from the head entry):
  - rf_we = !empty && drain_en.
  - rf_wa/rf_wd = head entry when !empty; 0 when empty.
  - When rf_we = 1 the head pops at that edge: valid bit cleared, read pointer advanced.
  - Latency: a request accepted at edge N can be written to the register file at edge N+1 at the earliest.
- Ordering: writes commit strictly in acceptance order, including repeated writes to the same register.
- Simultaneous accept and drain in one cycle: count unchanged; both pointers advance.
- Forwarding (combinational), evaluated independently for ra1 and ra2:
  - hit = ra != 0 and at least one valid entry has wa == ra.
  - data = the youngest matching entry, i.e. closest behind the write pointer; 0 when there is no hit.
  - The head entry being drained this cycle still counts as a hit, because the register file updates only at the edge.
  - An incoming in_* request in the same cycle is not forwarded (no same-cycle bypass).
- count, empty and full are derived from registered state only.

Test Plan:
- Reset: hold rst_n = 0 mid-stream with 3 entries queued -> immediately count = 0, empty = 1, rf_we = 0, in_ready = 1. After release, no queued write ever appears on rf_we.
- Basic flow: drain_en = 0; accept (wa=5, 0xAAAA0001) then (wa=6, 0xBBBB0002); set drain_en = 1 -> rf_we = 1 with (5, 0xAAAA0001) on one edge, then (6, 0xBBBB0002) on the next, then empty = 1, rf_wa = 0.
- Full / backpressure: drain_en = 0; push 4 entries -> full = 1, in_ready = 0. A fifth in_valid with drain_en = 1 is not accepted. Next cycle count = 3, in_ready = 1.
- x0 discard: accept (wa=0, 0xDEADBEEF) -> count stays 0, rf_we never asserts. With ra1 = 0 -> fwd_hit1 = 0.
- Forward youngest: queue (wa=7, 0x11), (wa=3, 0x22), (wa=7, 0x33); ra1 = 7, ra2 = 3 -> fwd_hit1 = 1, fwd_data1 = 0x33, fwd_hit2 = 1, fwd_data2 = 0x22. With ra1 = 9 -> fwd_hit1 = 0, fwd_data1 = 0.
- Wrap and simultaneous events: stream 10 requests with accept and drain every cycle -> count stays 1, pointers wrap past DEPTH, and rf_wa/rf_wd reproduce the input order exactly.
